// File: rtl/value_grant_arbiter_pkg.sv
// Shared definitions for the value-ordered grant arbiter.
// Holds the FSM state encoding, the fixed requester count and the index width.
package value_grant_arbiter_pkg;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned IDX_W   = 2;

    typedef enum logic {
        StIdle  = 1'b0,
        StGrant = 1'b1
    } state_t;

endpackage

// File: rtl/value_grant_arbiter_value_pair_select.sv
// value_pair_select: one node of the 4-way value-select tree.
// Picks the better of two (valid, value) candidates.
//   valid_a / value_a : candidate a (lower index side)
//   valid_b / value_b : candidate b (higher index side)
//   valid             : either candidate valid
//   value             : winning value
//   sel_b             : 1 when b wins (b strictly better, or a invalid)
module value_pair_select #(
    parameter int unsigned BW_VALUE   = 8,
    parameter bit          UNSIGNED   = 1'b1,
    parameter bit          SELECT_MIN = 1'b0
) (
    input  logic                valid_a,
    input  logic [BW_VALUE-1:0] value_a,
    input  logic                valid_b,
    input  logic [BW_VALUE-1:0] value_b,
    output logic                valid,
    output logic [BW_VALUE-1:0] value,
    output logic                sel_b
);

    // Flipping the sign bit maps two's-complement order onto unsigned order.
    localparam logic [BW_VALUE-1:0] SIGN_FLIP =
        UNSIGNED ? '0 : (BW_VALUE'(1) << (BW_VALUE - 1));

    logic [BW_VALUE-1:0] key_a;
    logic [BW_VALUE-1:0] key_b;
    logic                b_better;

    assign key_a    = value_a ^ SIGN_FLIP;
    assign key_b    = value_b ^ SIGN_FLIP;
    // Strict compare: a tie keeps a, so the lower index wins.
    assign b_better = SELECT_MIN ? (key_b < key_a) : (key_b > key_a);

    assign sel_b = !valid_a || (valid_b && b_better);
    assign valid = valid_a || valid_b;
    assign value = sel_b ? value_b : value_a;

endmodule

// File: rtl/value_grant_arbiter.sv
// value_grant_arbiter: picks the requester with the largest (or smallest) value
// and holds a registered one-hot grant until release, abandon or timeout.
//   clk, rst        : clock, asynchronous active-high reset
//   req_valid_list  : per-requester valid, bit i = requester i
//   req_value_list  : requester i at [BW_VALUE*(i+1)-1 -: BW_VALUE]
//   release_req     : owner ends its grant
//   grant_list      : registered one-hot grant
//   grant_valid     : registered OR of grant_list
//   grant_index     : registered owner index (kept after revoke)
//   grant_value     : winner value latched at grant time (kept after revoke)
//   timeout_pulse   : one-cycle pulse after a forced revoke
module value_grant_arbiter
    import value_grant_arbiter_pkg::*;
#(
    parameter int unsigned BW_VALUE   = 8,
    parameter bit          UNSIGNED   = 1'b1,
    parameter bit          SELECT_MIN = 1'b0,
    parameter int unsigned MAX_HOLD   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            req_valid_list,
    input  logic [4*BW_VALUE-1:0] req_value_list,
    input  logic                  release_req,
    output logic [3:0]            grant_list,
    output logic                  grant_valid,
    output logic [1:0]            grant_index,
    output logic [BW_VALUE-1:0]   grant_value,
    output logic                  timeout_pulse
);

    localparam int unsigned CNT_W     = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
    localparam int unsigned HOLD_LAST = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;

    // Selection tree
    logic                lo_valid, hi_valid, root_valid;
    logic [BW_VALUE-1:0] lo_value, hi_value, root_value;
    logic                lo_sel_b, hi_sel_b, root_sel_b;
    logic [IDX_W-1:0]    win_idx;

    value_pair_select #(
        .BW_VALUE   (BW_VALUE),
        .UNSIGNED   (UNSIGNED),
        .SELECT_MIN (SELECT_MIN)
    ) u_leaf_lo (
        .valid_a (req_valid_list[0]),
        .value_a (req_value_list[BW_VALUE*1-1 -: BW_VALUE]),
        .valid_b (req_valid_list[1]),
        .value_b (req_value_list[BW_VALUE*2-1 -: BW_VALUE]),
        .valid   (lo_valid),
        .value   (lo_value),
        .sel_b   (lo_sel_b)
    );

    value_pair_select #(
        .BW_VALUE   (BW_VALUE),
        .UNSIGNED   (UNSIGNED),
        .SELECT_MIN (SELECT_MIN)
    ) u_leaf_hi (
        .valid_a (req_valid_list[2]),
        .value_a (req_value_list[BW_VALUE*3-1 -: BW_VALUE]),
        .valid_b (req_valid_list[3]),
        .value_b (req_value_list[BW_VALUE*4-1 -: BW_VALUE]),
        .valid   (hi_valid),
        .value   (hi_value),
        .sel_b   (hi_sel_b)
    );

    value_pair_select #(
        .BW_VALUE   (BW_VALUE),
        .UNSIGNED   (UNSIGNED),
        .SELECT_MIN (SELECT_MIN)
    ) u_root (
        .valid_a (lo_valid),
        .value_a (lo_value),
        .valid_b (hi_valid),
        .value_b (hi_value),
        .valid   (root_valid),
        .value   (root_value),
        .sel_b   (root_sel_b)
    );

    // Root picks the pair, the chosen leaf picks the member.
    assign win_idx = root_sel_b ? {1'b1, hi_sel_b} : {1'b0, lo_sel_b};

    // State and output registers
    state_t              state_q, state_d;
    logic [3:0]          grant_list_q, grant_list_d;
    logic                grant_valid_q, grant_valid_d;
    logic [IDX_W-1:0]    grant_index_q, grant_index_d;
    logic [BW_VALUE-1:0] grant_value_q, grant_value_d;
    logic                timeout_q, timeout_d;
    logic [CNT_W-1:0]    hold_cnt_q, hold_cnt_d;
    logic                revoke;

    always_comb begin
        state_d       = state_q;
        grant_list_d  = grant_list_q;
        grant_valid_d = grant_valid_q;
        grant_index_d = grant_index_q;
        grant_value_d = grant_value_q;
        hold_cnt_d    = hold_cnt_q;
        timeout_d     = 1'b0;
        revoke        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (root_valid) begin
                    state_d       = StGrant;
                    grant_list_d  = 4'b0001 << win_idx;
                    grant_valid_d = 1'b1;
                    grant_index_d = win_idx;
                    grant_value_d = root_value;
                    hold_cnt_d    = '0;
                end
            end
            StGrant: begin
                if (release_req || !req_valid_list[grant_index_q]) begin
                    revoke = 1'b1;
                end else if (MAX_HOLD != 0 && hold_cnt_q == CNT_W'(HOLD_LAST)) begin
                    revoke    = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
                // Index and value stay latched for observers after revoke.
                if (revoke) begin
                    state_d       = StIdle;
                    grant_list_d  = '0;
                    grant_valid_d = 1'b0;
                    hold_cnt_d    = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            grant_list_q  <= '0;
            grant_valid_q <= 1'b0;
            grant_index_q <= '0;
            grant_value_q <= '0;
            timeout_q     <= 1'b0;
            hold_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            grant_list_q  <= grant_list_d;
            grant_valid_q <= grant_valid_d;
            grant_index_q <= grant_index_d;
            grant_value_q <= grant_value_d;
            timeout_q     <= timeout_d;
            hold_cnt_q    <= hold_cnt_d;
        end
    end

    assign grant_list    = grant_list_q;
    assign grant_valid   = grant_valid_q;
    assign grant_index   = grant_index_q;
    assign grant_value   = grant_value_q;
    assign timeout_pulse = timeout_q;

endmodule

// File: tb/tb_value_grant_arbiter.sv
// Testbench for value_grant_arbiter. Two instances share the stimulus:
//   inst 0 (a): unsigned, largest wins, MAX_HOLD=4
//   inst 1 (b): signed,   smallest wins, MAX_HOLD=4
// A behavioural model pushes per-cycle expectations into a scoreboard queue
// before each edge; they are popped and compared after the edge.
module tb_value_grant_arbiter;

    localparam int BW   = 8;
    localparam int MAXH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    req_valid;
    logic [4*BW-1:0] req_value;
    logic          release_req;

    logic [3:0]    a_list, b_list;
    logic          a_valid, b_valid;
    logic [1:0]    a_idx, b_idx;
    logic [BW-1:0] a_val, b_val;
    logic          a_to, b_to;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    value_grant_arbiter #(
        .BW_VALUE   (BW),
        .UNSIGNED   (1'b1),
        .SELECT_MIN (1'b0),
        .MAX_HOLD   (MAXH)
    ) u_dut_a (
        .clk            (clk),
        .rst            (rst),
        .req_valid_list (req_valid),
        .req_value_list (req_value),
        .release_req    (release_req),
        .grant_list     (a_list),
        .grant_valid    (a_valid),
        .grant_index    (a_idx),
        .grant_value    (a_val),
        .timeout_pulse  (a_to)
    );

    value_grant_arbiter #(
        .BW_VALUE   (BW),
        .UNSIGNED   (1'b0),
        .SELECT_MIN (1'b1),
        .MAX_HOLD   (MAXH)
    ) u_dut_b (
        .clk            (clk),
        .rst            (rst),
        .req_valid_list (req_valid),
        .req_value_list (req_value),
        .release_req    (release_req),
        .grant_list     (b_list),
        .grant_valid    (b_valid),
        .grant_index    (b_idx),
        .grant_value    (b_val),
        .timeout_pulse  (b_to)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model state, one slot per instance
    logic          m_grant [2];
    logic [3:0]    m_list  [2];
    logic [1:0]    m_idx   [2];
    logic [BW-1:0] m_val   [2];
    int            m_cnt   [2];
    logic          m_to    [2];

    typedef struct {
        string         tag;
        int            inst;
        logic [3:0]    list;
        logic          valid;
        logic [1:0]    idx;
        logic [BW-1:0] val;
        logic          to;
    } exp_t;

    exp_t sb[$];

    function automatic logic [BW-1:0] val_of(input int i);
        logic [4*BW-1:0] v;
        v = req_value;
        return v[BW*i +: BW];
    endfunction

    // x strictly better than y for instance k
    function automatic logic better(input int k, input logic [BW-1:0] x, input logic [BW-1:0] y);
        if (k == 0) return x > y;
        return $signed(x) < $signed(y);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_grant[k] = 1'b0; m_list[k] = '0; m_idx[k] = '0;
            m_val[k] = '0; m_cnt[k] = 0; m_to[k] = 1'b0;
        end
    endtask

    task automatic model_step(input int k);
        int w;
        if (m_grant[k]) begin
            m_to[k] = 1'b0;
            if (release_req || !req_valid[m_idx[k]]) begin
                m_grant[k] = 1'b0; m_list[k] = '0; m_cnt[k] = 0;
            end else if (m_cnt[k] == MAXH - 1) begin
                m_grant[k] = 1'b0; m_list[k] = '0; m_cnt[k] = 0; m_to[k] = 1'b1;
            end else begin
                m_cnt[k]++;
            end
        end else begin
            m_to[k] = 1'b0;
            w = -1;
            for (int i = 0; i < 4; i++)
                if (req_valid[i] && (w < 0 || better(k, val_of(i), val_of(w)))) w = i;
            if (w >= 0) begin
                m_grant[k] = 1'b1;
                m_list[k]  = 4'(1 << w);
                m_idx[k]   = 2'(w);
                m_val[k]   = val_of(w);
                m_cnt[k]   = 0;
            end
        end
    endtask

    // One clock: push expectations, take the edge, drain the scoreboard.
    task automatic step(input string tag);
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            model_step(k);
            e.tag = tag; e.inst = k; e.list = m_list[k]; e.valid = m_grant[k];
            e.idx = m_idx[k]; e.val = m_val[k]; e.to = m_to[k];
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.inst == 0) begin
                check({e.tag, "/a.list"},  32'(a_list),  32'(e.list));
                check({e.tag, "/a.valid"}, 32'(a_valid), 32'(e.valid));
                check({e.tag, "/a.idx"},   32'(a_idx),   32'(e.idx));
                check({e.tag, "/a.val"},   32'(a_val),   32'(e.val));
                check({e.tag, "/a.to"},    32'(a_to),    32'(e.to));
            end else begin
                check({e.tag, "/b.list"},  32'(b_list),  32'(e.list));
                check({e.tag, "/b.valid"}, 32'(b_valid), 32'(e.valid));
                check({e.tag, "/b.idx"},   32'(b_idx),   32'(e.idx));
                check({e.tag, "/b.val"},   32'(b_val),   32'(e.val));
                check({e.tag, "/b.to"},    32'(b_to),    32'(e.to));
            end
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "/a.list"}, 32'(a_list), 0);
        check({tag, "/a.valid"}, 32'(a_valid), 0);
        check({tag, "/a.idx"}, 32'(a_idx), 0);
        check({tag, "/a.val"}, 32'(a_val), 0);
        check({tag, "/a.to"}, 32'(a_to), 0);
        check({tag, "/b.valid"}, 32'(b_valid), 0);
        check({tag, "/b.val"}, 32'(b_val), 0);
    endtask

    initial begin
        int hi_cycles;
        logic seen_to;

        rst = 1'b1; req_valid = '0; req_value = '0; release_req = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_zero("reset");
        step("idle");

        // Unsigned max 3/9/9/1: tie between 1 and 2 goes to 1
        req_valid = 4'b1111;
        req_value = {8'd1, 8'd9, 8'd9, 8'd3};
        step("first");
        check("plan.max.list", 32'(a_list), 32'h2);
        check("plan.max.val", 32'(a_val), 32'd9);
        check("plan.min.idx", 32'(b_idx), 32'd3);
        step("hold");

        // Release and re-arbitrate after one idle cycle
        release_req = 1'b1;
        step("release");
        check("plan.rel.valid", 32'(a_valid), 32'd0);
        release_req = 1'b0;
        step("regrant");
        check("plan.regrant.idx", 32'(a_idx), 32'd1);
        check("plan.regrant.valid", 32'(a_valid), 32'd1);

        // Owner 1 abandons; requester 2 takes over one cycle later
        req_valid = 4'b1101;
        step("abandon");
        check("plan.aband.to", 32'(a_to), 32'd0);
        step("next");
        check("plan.next.idx", 32'(a_idx), 32'd2);

        // Timeout: requester 2 keeps holding
        hi_cycles = 1;
        seen_to   = 1'b0;
        for (int i = 0; i < 8 && !seen_to; i++) begin
            step("hold_to");
            if (a_to) seen_to = 1'b1;
            else if (a_valid) hi_cycles++;
        end
        check("plan.to.cycles", 32'(hi_cycles), 32'(MAXH));
        check("plan.to.seen", 32'(seen_to), 32'd1);

        // Regrant, then release in the last hold cycle: no timeout pulse
        step("regrant2");
        repeat (MAXH - 1) step("hold2");
        release_req = 1'b1;
        step("rel_last");
        check("plan.rellast.to", 32'(a_to), 32'd0);
        check("plan.rellast.valid", 32'(a_valid), 32'd0);
        release_req = 1'b0;

        // Signed min: 0x05 / 0xF0 / 0x7F / invalid
        req_valid = 4'b0000;
        step("drain");
        step("drain");
        req_valid = 4'b0111;
        req_value = {8'h00, 8'h7F, 8'hF0, 8'h05};
        step("signed");
        check("plan.smin.idx", 32'(b_idx), 32'd1);
        check("plan.smin.val", 32'(b_val), 32'hF0);
        step("signed_hold");

        // Asynchronous reset mid-grant
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_zero("async_rst");
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_zero("rst_held");
        step("post_rst");
        check("plan.postrst.valid", 32'(a_valid), 32'd1);

        // Random traffic
        for (int i = 0; i < 60; i++) begin
            req_valid   = 4'($urandom_range(0, 15));
            req_value   = $urandom;
            release_req = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) != 0) req_valid = req_valid | {3'b000, m_grant[0]};
            step("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
